efi_output_bank: RTL

Parametrised bank of angle-triggered, time-limited output drivers for ignition coils and injectors, one per channel. It replaces fixed per-output wiring such as the current 4-ignition / 2-injector split. It sits between the crank decoder (angle, sync) and the GPIO pins, and is configured from the SPI register map in the `clk` domain. Each channel fires when engine angle reaches its programmed start angle, stays on for a programmed number of timebase ticks, and is clamped by a hard maximum on-time.

---
 rtl/efi_output_bank_if.sv | 60 ++++++
 rtl/efi_output_bank.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/efi_output_bank_if.sv
// efi_output_bank_if
// -------------------
// Groups the engine-angle, timebase, configuration and driver signals of the
// output bank so the crank decoder / register map side and the bank itself
// can be wired with a single port.
//
// Signals:
//   angle      current engine angle from the crank decoder
//   angle_stb  one-cycle pulse when angle takes a new value
//   synced     decoder has crank/cam sync
//   tick       duration timebase enable, one clk wide
//   cfg_we     write strobe for one channel configuration
//   cfg_ch     target channel of the write
//   cfg_en     channel enable
//   cfg_start  trigger angle
//   cfg_dur    on-time in ticks
//   fault_clr  clears all fault bits
//   out        driver outputs, active high
//   busy       channel currently ON
//   fault      sticky per-channel configuration fault
//
// Modports:
//   master  the side that drives angle/config (decoder + register map)
//   slave   the output bank itself

interface efi_output_bank_if #(
    parameter int CHANNELS = 6,
    parameter int ANGLE_W  = 12,
    parameter int DUR_W    = 16
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [ANGLE_W-1:0]  angle;
    logic                angle_stb;
    logic                synced;
    logic                tick;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic                cfg_en;
    logic [ANGLE_W-1:0]  cfg_start;
    logic [DUR_W-1:0]    cfg_dur;
    logic                fault_clr;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] fault;

    modport master (
        output angle, angle_stb, synced, tick,
        output cfg_we, cfg_ch, cfg_en, cfg_start, cfg_dur, fault_clr,
        input  out, busy, fault
    );

    modport slave (
        input  angle, angle_stb, synced, tick,
        input  cfg_we, cfg_ch, cfg_en, cfg_start, cfg_dur, fault_clr,
        output out, busy, fault
    );

endinterface

// File: rtl/efi_output_bank.sv
// efi_output_bank
// ---------------
// Parametrised bank of angle-triggered, time-limited output drivers for
// ignition coils and injectors. Every channel fires when the engine angle
// strobe matches its programmed start angle, stays on for a programmed number
// of timebase ticks and is clamped to a hard maximum on-time.
//
// Each channel keeps a pending configuration (written from the register map)
// and an active configuration (used for triggering and pulse length). The
// pending copy is promoted whenever the channel is idle, so a write never
// disturbs a pulse that is already running.
//
// Ports:
//   clk      block clock
//   reset_n  asynchronous, active-low reset
//   bus      efi_output_bank_if slave modport (angle, sync, tick, config
//            write, fault clear in; out/busy/fault out)

module efi_output_bank #(
    parameter int CHANNELS  = 6,
    parameter int ANGLE_W   = 12,
    parameter int ANGLE_MAX = 3600,
    parameter int DUR_W     = 16,
    parameter int MAX_ON    = 20000
) (
    input  logic               clk,
    input  logic               reset_n,
    efi_output_bank_if.slave   bus
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef struct packed {
        logic               en;
        logic [ANGLE_W-1:0] start;
        logic [DUR_W-1:0]   dur;
    } cfg_t;

    typedef enum logic {
        IDLE = 1'b0,
        ON   = 1'b1
    } state_t;

    cfg_t                pend_q  [CHANNELS];
    cfg_t                pend_d  [CHANNELS];
    cfg_t                act_q   [CHANNELS];
    cfg_t                act_d   [CHANNELS];
    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [DUR_W-1:0]    cnt_q   [CHANNELS];
    logic [DUR_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] fault_q;
    logic [CHANNELS-1:0] fault_d;
    logic [CHANNELS-1:0] onVec;

    logic wrHit;
    logic startBad;
    logic durBig;
    cfg_t wrCfg;

    // Decode the incoming configuration write once for all channels. Writes
    // to channel numbers beyond the bank are silently dropped; an over-long
    // duration is clamped rather than rejected so the channel stays usable.
    always_comb begin
        wrHit     = bus.cfg_we && (32'(bus.cfg_ch) < CHANNELS);
        startBad  = 32'(bus.cfg_start) >= ANGLE_MAX;
        durBig    = 32'(bus.cfg_dur) > MAX_ON;
        wrCfg.en    = bus.cfg_en;
        wrCfg.start = bus.cfg_start;
        wrCfg.dur   = durBig ? DUR_W'(MAX_ON) : bus.cfg_dur;
    end

    // Next-state logic for every channel: config promotion, config write,
    // the IDLE/ON machine with its tick counter, and the sticky fault bits.
    // Fault clear is applied first so a fault raised in the same cycle wins.
    // Loss of sync overrides everything else and parks the channel.
    always_comb begin
        fault_d = bus.fault_clr ? '0 : fault_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pend_d[i]  = pend_q[i];
            act_d[i]   = act_q[i];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (state_q[i] == IDLE && pend_q[i] != act_q[i]) begin
                act_d[i] = pend_q[i];
            end

            if (wrHit && bus.cfg_ch == CH_W'(i)) begin
                if (startBad) begin
                    fault_d[i] = 1'b1;
                end else begin
                    pend_d[i] = wrCfg;
                    if (durBig) begin
                        fault_d[i] = 1'b1;
                    end
                end
            end

            case (state_q[i])
                IDLE: begin
                    if (bus.synced && bus.angle_stb && act_q[i].en &&
                        bus.angle == act_q[i].start && act_q[i].dur != '0) begin
                        state_d[i] = ON;
                        cnt_d[i]   = act_q[i].dur;
                    end
                end
                ON: begin
                    if (bus.tick) begin
                        if (cnt_q[i] == DUR_W'(1)) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            if (!bus.synced) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end
        end
    end

    // State register for all channels, cleared asynchronously so the drivers
    // are released the moment reset is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend_q[i]  <= '0;
                act_q[i]   <= '0;
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            fault_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend_q[i]  <= pend_d[i];
                act_q[i]   <= act_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_q <= fault_d;
        end
    end

    // The driver outputs are a pure decode of the state registers, so no
    // input can glitch a coil or injector pin combinationally.
    always_comb begin
        onVec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            onVec[i] = (state_q[i] == ON);
        end
    end

    assign bus.out   = onVec;
    assign bus.busy  = onVec;
    assign bus.fault = fault_q;

endmodule
